// File: rtl/adau_spi_responder.sv
// -----------------------------------------------------------------------------
// adau_spi_responder
//
// SPI control-port responder that stands in for the ADAU1761 register
// interface. CCLK, CLATCH and CDATA are oversampled in the system clock.
// After three dummy latch pulses the port enters SPI mode. From then on it
// decodes {header, 16-bit address, data...} frames with burst
// auto-increment. Each write into the byte register file is reported with
// a single-cycle strobe.
//
// Optional build macro:
//   ADAU_RESP_READBACK_EN - enables register read-back on spi_miso. When it
//                           is undefined, read frames are skipped and MISO is
//                           never driven.
// -----------------------------------------------------------------------------
module adau_spi_responder #(
    parameter logic [6:0]  CHIP_ADDR = 7'h00,
    parameter logic [15:0] REG_BASE  = 16'h4000,
    parameter int          NUM_REGS  = 256
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        spi_sclk,
    input  logic        spi_cs_n,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        spi_miso_oe,
    output logic        spi_mode,
    output logic        reg_wr_valid,
    output logic [15:0] reg_wr_addr,
    output logic [7:0]  reg_wr_data,
    output logic        core_clk_en
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_ADDR = 3'd2,
        ST_DATA = 3'd3,
        ST_SKIP = 3'd4
    } state_t;

    // True when an absolute register address falls inside the mapped window.
    function automatic logic addr_in_range(input logic [15:0] addr);
        logic [16:0] lo_v;
        logic [16:0] hi_v;
        lo_v = {1'b0, REG_BASE};
        hi_v = {1'b0, REG_BASE} + 17'(NUM_REGS);
        return ({1'b0, addr} >= lo_v) && ({1'b0, addr} < hi_v);
    endfunction

    // Register file index of an absolute address. It is only meaningful when
    // addr_in_range() is true.
    function automatic logic [IDX_W-1:0] addr_index(input logic [15:0] addr);
        return IDX_W'(addr - REG_BASE);
    endfunction

    // Synchronizer chains: [0] and [1] form the 2-flop synchronizer, and
    // [2] is the delayed copy used for edge detection.
    logic [2:0]  sclk_sync_r;
    logic [2:0]  cs_sync_r;
    logic [1:0]  mosi_sync_r;

    logic        sclk_rise_s;
    logic        cs_rise_s;
    logic        cs_fall_s;
    logic        mosi_s;

    state_t      state_r;
    logic [3:0]  bit_cnt_r;
    logic [15:0] shift_r;
    logic [15:0] shift_nxt_s;
    logic [15:0] ptr_r;
    logic [1:0]  dummy_cnt_r;
    logic        spi_mode_r;
    logic        reg_wr_valid_r;
    logic [15:0] reg_wr_addr_r;
    logic [7:0]  reg_wr_data_r;
    logic        core_clk_en_r;

    logic [7:0]  reg_file_r [NUM_REGS];

    logic             wr_en_s;
    logic [IDX_W-1:0] wr_idx_s;
    logic             rd_frame_s;

`ifdef ADAU_RESP_READBACK_EN
    logic        sclk_fall_s;
    logic        rd_frame_r;
    logic        miso_r;
    logic        miso_oe_r;
    logic [7:0]  tx_r;
    logic [15:0] rd_addr_s;
    logic [7:0]  rd_byte_s;
`endif

    assign sclk_rise_s = sclk_sync_r[1] & ~sclk_sync_r[2];
    assign cs_rise_s   = cs_sync_r[1] & ~cs_sync_r[2];
    assign cs_fall_s   = ~cs_sync_r[1] & cs_sync_r[2];
    assign mosi_s      = mosi_sync_r[1];

`ifdef ADAU_RESP_READBACK_EN
    assign sclk_fall_s = ~sclk_sync_r[1] & sclk_sync_r[2];
    assign rd_frame_s  = rd_frame_r;
    assign spi_miso    = miso_r;
    assign spi_miso_oe = miso_oe_r;
`else
    assign rd_frame_s  = 1'b0;
    assign spi_miso    = 1'b0;
    assign spi_miso_oe = 1'b0;
`endif

    assign spi_mode     = spi_mode_r;
    assign reg_wr_valid = reg_wr_valid_r;
    assign reg_wr_addr  = reg_wr_addr_r;
    assign reg_wr_data  = reg_wr_data_r;
    assign core_clk_en  = core_clk_en_r;

    // Bring the asynchronous SPI pins into the clk domain. cs idles high, so
    // reset does not fabricate a latch edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_sync_r <= 3'b000;
            cs_sync_r   <= 3'b111;
            mosi_sync_r <= 2'b00;
        end else begin
            sclk_sync_r <= {sclk_sync_r[1:0], spi_sclk};
            cs_sync_r   <= {cs_sync_r[1:0], spi_cs_n};
            mosi_sync_r <= {mosi_sync_r[0], spi_mosi};
        end
    end

    // Next shift value and write / read-fetch decode for the current clk.
    always_comb begin
        shift_nxt_s = {shift_r[14:0], mosi_s};
        wr_idx_s    = addr_index(ptr_r);
        if (sclk_rise_s && (state_r == ST_DATA) && (bit_cnt_r == 4'd7) &&
            !rd_frame_s && addr_in_range(ptr_r)) begin
            wr_en_s = 1'b1;
        end else begin
            wr_en_s = 1'b0;
        end
`ifdef ADAU_RESP_READBACK_EN
        // Fetch target: the freshly shifted address when ADDR completes,
        // otherwise the byte after the pointer when a data byte completes.
        if (state_r == ST_ADDR) begin
            rd_addr_s = shift_nxt_s;
        end else begin
            rd_addr_s = ptr_r + 16'd1;
        end
        if (addr_in_range(rd_addr_s)) begin
            rd_byte_s = reg_file_r[addr_index(rd_addr_s)];
        end else begin
            rd_byte_s = 8'h00;
        end
`endif
    end

    // Byte register file: cleared on reset and written by completed write bytes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                reg_file_r[i] <= 8'h00;
            end
        end else if (wr_en_s) begin
            reg_file_r[wr_idx_s] <= shift_nxt_s[7:0];
        end
    end

    // Frame decoder: mode entry, the HDR/ADDR/DATA/SKIP sequence, the write
    // strobe and the read-back shifter. A cs rise is handled last, so a byte
    // that completes in the same clk still commits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r        <= ST_IDLE;
            bit_cnt_r      <= 4'd0;
            shift_r        <= 16'h0000;
            ptr_r          <= 16'h0000;
            dummy_cnt_r    <= 2'd0;
            spi_mode_r     <= 1'b0;
            reg_wr_valid_r <= 1'b0;
            reg_wr_addr_r  <= 16'h0000;
            reg_wr_data_r  <= 8'h00;
            core_clk_en_r  <= 1'b0;
`ifdef ADAU_RESP_READBACK_EN
            rd_frame_r     <= 1'b0;
            miso_r         <= 1'b0;
            miso_oe_r      <= 1'b0;
            tx_r           <= 8'h00;
`endif
        end else begin
            reg_wr_valid_r <= 1'b0;
            core_clk_en_r  <= reg_file_r[0][0];

            if (sclk_rise_s) begin
                shift_r <= shift_nxt_s;
                case (state_r)
                    ST_HDR: begin
                        if (bit_cnt_r == 4'd7) begin
                            bit_cnt_r <= 4'd0;
                            if (shift_nxt_s[7:1] != CHIP_ADDR) begin
                                state_r <= ST_SKIP;
`ifdef ADAU_RESP_READBACK_EN
                            end else begin
                                rd_frame_r <= shift_nxt_s[0];
                                state_r    <= ST_ADDR;
                            end
`else
                            end else if (shift_nxt_s[0]) begin
                                state_r <= ST_SKIP;
                            end else begin
                                state_r <= ST_ADDR;
                            end
`endif
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 4'd1;
                        end
                    end
                    ST_ADDR: begin
                        if (bit_cnt_r == 4'd15) begin
                            bit_cnt_r <= 4'd0;
                            ptr_r     <= shift_nxt_s;
                            state_r   <= ST_DATA;
`ifdef ADAU_RESP_READBACK_EN
                            tx_r      <= rd_byte_s;
`endif
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 4'd1;
                        end
                    end
                    ST_DATA: begin
                        if (bit_cnt_r == 4'd7) begin
                            bit_cnt_r <= 4'd0;
                            ptr_r     <= ptr_r + 16'd1;
                            if (wr_en_s) begin
                                reg_wr_valid_r <= 1'b1;
                                reg_wr_addr_r  <= ptr_r;
                                reg_wr_data_r  <= shift_nxt_s[7:0];
                            end
`ifdef ADAU_RESP_READBACK_EN
                            tx_r      <= rd_byte_s;
`endif
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 4'd1;
                        end
                    end
                    default: begin
                        // IDLE and SKIP ignore data bits.
                    end
                endcase
            end

`ifdef ADAU_RESP_READBACK_EN
            if (sclk_fall_s && (state_r == ST_DATA) && rd_frame_r) begin
                miso_r    <= tx_r[7];
                tx_r      <= {tx_r[6:0], 1'b0};
                miso_oe_r <= 1'b1;
            end
`endif

            if (cs_fall_s) begin
                bit_cnt_r <= 4'd0;
                if ((state_r == ST_IDLE) && spi_mode_r) begin
                    state_r <= ST_HDR;
                end
            end

            if (cs_rise_s) begin
                state_r   <= ST_IDLE;
                bit_cnt_r <= 4'd0;
`ifdef ADAU_RESP_READBACK_EN
                miso_r    <= 1'b0;
                miso_oe_r <= 1'b0;
`endif
                if (!spi_mode_r) begin
                    if (dummy_cnt_r != 2'd3) begin
                        dummy_cnt_r <= dummy_cnt_r + 2'd1;
                    end
                    if (dummy_cnt_r == 2'd2) begin
                        spi_mode_r <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_adau_spi_responder.sv
// -----------------------------------------------------------------------------
// tb_adau_spi_responder
//
// Directed and random SPI frames for adau_spi_responder. The reference model
// works at frame level: a byte-array register file, a mode flag and a
// dummy-frame count. It predicts the write strobes, the read-back bytes and
// the output state after every frame. Honours ADAU_RESP_READBACK_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_adau_spi_responder;

    localparam int GAP_NS = 200;

    logic        clk;
    logic        reset_n;
    logic        spi_sclk;
    logic        spi_cs_n;
    logic        spi_mosi;
    logic        spi_miso;
    logic        spi_miso_oe;
    logic        spi_mode;
    logic        reg_wr_valid;
    logic [15:0] reg_wr_addr;
    logic [7:0]  reg_wr_data;
    logic        core_clk_en;

    adau_spi_responder dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .spi_sclk     (spi_sclk),
        .spi_cs_n     (spi_cs_n),
        .spi_mosi     (spi_mosi),
        .spi_miso     (spi_miso),
        .spi_miso_oe  (spi_miso_oe),
        .spi_mode     (spi_mode),
        .reg_wr_valid (reg_wr_valid),
        .reg_wr_addr  (reg_wr_addr),
        .reg_wr_data  (reg_wr_data),
        .core_clk_en  (core_clk_en)
    );

    // 50 MHz system clock.
    initial clk = 1'b0;
    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int half_ns = 500;

    // Frame being sent and the MISO bytes captured at each sclk rise.
    logic [7:0]  fr_q[$];
    logic [7:0]  rx_q[$];
    int          oe_bad;

    // Reference model state.
    logic [7:0]  m_mem [256];
    bit          m_mode;
    int          m_dummy;
    logic [23:0] exp_wr_q[$];
    logic [7:0]  exp_rx_q[$];
    logic        exp_oe;

    // Write strobes seen on the DUT outputs, plus a back-to-back detector.
    logic [23:0] obs_wr_q[$];
    int          obs_start;
    logic        prev_valid = 1'b0;
    int          bb_viol = 0;

    always @(negedge clk) begin
        if (reg_wr_valid === 1'b1) begin
            obs_wr_q.push_back({reg_wr_addr, reg_wr_data});
            if (prev_valid) bb_viol <= bb_viol + 1;
        end
        prev_valid <= reg_wr_valid;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit in_rng(input logic [15:0] a);
        return (a >= 16'h4000) && (a <= 16'h40FF);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
        m_mode  = 1'b0;
        m_dummy = 0;
    endtask

    // Frame-level prediction for the bytes in fr_q, cut off after nbits bits.
    task automatic model_frame(input int nbits);
        int          nd;
        logic [15:0] a;
        exp_wr_q = {};
        exp_rx_q = {};
        exp_oe   = 1'b0;
        nd = (nbits >= 24) ? (nbits - 24) / 8 : 0;
        for (int k = 0; k < nd; k++) exp_rx_q.push_back(8'h00);
        if (!m_mode) begin
            m_dummy++;
            if (m_dummy >= 3) m_mode = 1'b1;
            return;
        end
        if (nbits < 24) return;
        if (fr_q[0][7:1] != 7'h00) return;
        a = {fr_q[1], fr_q[2]};
        if (fr_q[0][0]) begin
`ifdef ADAU_RESP_READBACK_EN
            exp_oe = 1'b1;
            for (int k = 0; k < nd; k++) begin
                exp_rx_q[k] = in_rng(a) ? m_mem[8'(a - 16'h4000)] : 8'h00;
                a = a + 16'd1;
            end
`endif
            return;
        end
        for (int k = 0; k < nd; k++) begin
            if (in_rng(a)) begin
                m_mem[8'(a - 16'h4000)] = fr_q[3 + k];
                exp_wr_q.push_back({a, fr_q[3 + k]});
            end
            a = a + 16'd1;
        end
    endtask

    // Drive nbits of fr_q MSB first (CPOL=0); sample MISO/OE at each rise.
    task automatic send_frame(input int nbits, input bit keep_cs);
        logic [7:0] rb;
        rx_q   = {};
        oe_bad = 0;
        rb     = 8'h00;
        spi_cs_n = 1'b0;
        #(half_ns);
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = fr_q[i / 8][7 - (i % 8)];
            #(half_ns);
            if (i >= 24) begin
                rb = {rb[6:0], spi_miso};
                if (spi_miso_oe !== exp_oe) oe_bad++;
                if ((i % 8) == 7) rx_q.push_back(rb);
            end else if (spi_miso_oe !== 1'b0) begin
                oe_bad++;
            end
            spi_sclk = 1'b1;
            #(half_ns);
            spi_sclk = 1'b0;
        end
        if (!keep_cs) begin
            #(half_ns);
            spi_cs_n = 1'b1;
            spi_mosi = 1'b0;
            #(GAP_NS);
        end
    endtask

    // Predict, send, then compare strobes, read-back bytes and output state.
    task automatic run_frame(input int nbits, input string tag);
        model_frame(nbits);
        obs_start = obs_wr_q.size();
        send_frame(nbits, 1'b0);
        chk({tag, ":wr_count"}, 32'(obs_wr_q.size() - obs_start), 32'(exp_wr_q.size()));
        for (int k = 0; k < exp_wr_q.size() && (obs_start + k) < obs_wr_q.size(); k++)
            chk({tag, ":wr_entry"}, 32'(obs_wr_q[obs_start + k]), 32'(exp_wr_q[k]));
        chk({tag, ":rx_count"}, 32'(rx_q.size()), 32'(exp_rx_q.size()));
        for (int k = 0; k < exp_rx_q.size() && k < rx_q.size(); k++)
            chk({tag, ":miso_byte"}, 32'(rx_q[k]), 32'(exp_rx_q[k]));
        chk({tag, ":oe_window"}, 32'(oe_bad), 32'd0);
        chk({tag, ":spi_mode"}, 32'(spi_mode), 32'(m_mode));
        chk({tag, ":core_clk_en"}, 32'(core_clk_en), 32'(m_mem[0][0]));
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        spi_cs_n = 1'b1;
        spi_sclk = 1'b0;
        spi_mosi = 1'b0;
        model_reset();
        #100;
        @(negedge clk);
        reset_n = 1'b1;
        #100;
    endtask

    initial begin
        logic [7:0]  hdr;
        logic [15:0] a;
        int          nd;
        int          nbits;

        // Reset state.
        reset_n  = 1'b0;
        spi_cs_n = 1'b1;
        spi_sclk = 1'b0;
        spi_mosi = 1'b0;
        model_reset();
        #1;
        chk("reset_outputs",
            32'({spi_miso, spi_miso_oe, spi_mode, reg_wr_valid, reg_wr_addr, reg_wr_data, core_clk_en}),
            32'd0);
        chk("reset_reg0", 32'(dut.reg_file_r[0]), 32'd0);
        #100;
        @(negedge clk);
        reset_n = 1'b1;
        #100;

        // Mode entry at 1 MHz sclk: three dummy frames, then the first write.
        half_ns = 500;
        fr_q = {8'h00, 8'h00, 8'h00, 8'h00};
        run_frame(32, "dummy1");
        run_frame(32, "dummy2");
        run_frame(32, "dummy3");
        fr_q = {8'h00, 8'h40, 8'h00, 8'h01};
        run_frame(32, "first_wr");
        chk("first_wr_clk_en", 32'(core_clk_en), 32'd1);

        // Fresh reset: a single write frame only counts as a dummy.
        half_ns = 200;
        do_reset();
        fr_q = {8'h00, 8'h40, 8'h00, 8'h01};
        run_frame(32, "no_mode_wr");
        chk("no_mode_flag", 32'(spi_mode), 32'd0);
        fr_q = {8'h00, 8'h00, 8'h00, 8'h00};
        run_frame(32, "dummy_b2");
        run_frame(32, "dummy_b3");

        // Burst with auto-increment.
        fr_q = {8'h00, 8'h40, 8'hF9, 8'hFF, 8'h03};
        run_frame(40, "burst");
        chk("burst_reg_f9", 32'(dut.reg_file_r[8'hF9]), 32'h0000_00FF);
        chk("burst_reg_fa", 32'(dut.reg_file_r[8'hFA]), 32'h0000_0003);

        // Write, then read back.
        fr_q = {8'h00, 8'h40, 8'h16, 8'h40};
        run_frame(32, "wr_4016");
        fr_q = {8'h01, 8'h40, 8'h16, 8'h00};
        run_frame(32, "rd_4016");

        // Wrong chip address, then an aborted frame, then a good one.
        fr_q = {8'h02, 8'h40, 8'h1C, 8'h21};
        run_frame(32, "wrong_chip");
        fr_q = {8'h00, 8'h40, 8'h1E, 8'h41};
        run_frame(20, "abort20");
        run_frame(32, "after_abort");
        chk("after_abort_reg", 32'(dut.reg_file_r[8'h1E]), 32'h0000_0041);

        // Random frames: mostly valid chip and in-window addresses, plus edges and truncation.
        for (int f = 0; f < 24; f++) begin
            hdr = 8'h00;
            if ($urandom_range(9) == 0) hdr[7:1] = 7'($urandom_range(127, 1));
            if ($urandom_range(3) == 0) hdr[0] = 1'b1;
            case ($urandom_range(3))
                0:       a = 16'h4000 + 16'($urandom_range(255));
                1:       a = 16'h3FFE + 16'($urandom_range(3));
                2:       a = 16'h40FE + 16'($urandom_range(3));
                default: a = 16'hFFFF;
            endcase
            nd = $urandom_range(3, 1);
            fr_q = {hdr, a[15:8], a[7:0]};
            for (int k = 0; k < nd; k++) fr_q.push_back(8'($urandom));
            nbits = 24 + 8 * nd;
            if ($urandom_range(4) == 0) nbits = $urandom_range(nbits - 1, 1);
            run_frame(nbits, "random");
        end

        // Whole register file against the model.
        for (int i = 0; i < 256; i++)
            chk("regfile", 32'(dut.reg_file_r[i]), 32'(m_mem[i]));

        // Reset in the middle of a data byte.
        fr_q = {8'h00, 8'h40, 8'h00, 8'h01};
        run_frame(32, "pre_reset_wr");
        fr_q = {8'h00, 8'h40, 8'h00, 8'h55};
        exp_oe = 1'b0;
        send_frame(28, 1'b1);
        #3;
        reset_n = 1'b0;
        #1;
        chk("midreset_outputs",
            32'({spi_miso, spi_miso_oe, spi_mode, reg_wr_valid, reg_wr_addr, reg_wr_data, core_clk_en}),
            32'd0);
        chk("midreset_reg0", 32'(dut.reg_file_r[0]), 32'd0);
        spi_cs_n = 1'b1;
        spi_sclk = 1'b0;
        spi_mosi = 1'b0;
        model_reset();
        #200;
        @(negedge clk);
        reset_n = 1'b1;
        #200;
        fr_q = {8'h00, 8'h40, 8'h00, 8'h01};
        run_frame(32, "re_dummy1");
        run_frame(32, "re_dummy2");
        run_frame(32, "re_dummy3");
        run_frame(32, "re_first_wr");

        chk("no_back_to_back", 32'(bb_viol), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adau_spi_responder.md
Name: adau_spi_responder

Overview:
- SPI control-port responder modelling the ADAU1761 register interface; the target end of the command stream produced by the codec init sequencer and its SPI master.
- Oversamples CCLK/CLATCH/COUT-CDATA in the system clock, decodes 32-bit (and burst) frames, holds a byte register file and reports each register write.
- Used as an in-fabric codec stand-in for loopback/self-test builds and as the bench target for the init path.

Parameters:
- CHIP_ADDR, 7'h00, required value of frame header bits [7:1].
- REG_BASE, 16'h4000, register address mapped to file index 0.
- NUM_REGS, 256, register file depth in bytes; power of two, max 256.

Ports:
- clk  in  1  system clock; must be at least 8x the SCLK frequency.
- reset_n  in  1  asynchronous active-low reset.
- spi_sclk  in  1  SPI clock, CPOL=0, asynchronous.
- spi_cs_n  in  1  chip select / CLATCH, active low, asynchronous.
- spi_mosi  in  1  serial data in, MSB first.
- spi_miso  out  1  serial read data, MSB first.
- spi_miso_oe  out  1  high while the read data phase is driven.
- spi_mode  out  1  control port has entered SPI mode.
- reg_wr_valid  out  1  one-cycle write strobe.
- reg_wr_addr  out  16  absolute address of the write.
- reg_wr_data  out  8  data of the write.
- core_clk_en  out  1  live copy of bit 0 of register REG_BASE+0.

Behaviour:
- Reset: all outputs 0, register file cleared to 0x00, FSM in IDLE, dummy-frame counter 0.
- Inputs pass through 2-flop synchronizers plus one edge-detect stage.
  - sclk rise = sample point. sclk fall = MISO update point. cs rise = frame end.
  - Input-to-action latency is 3 clk.
- SPI mode entry:
  - Before spi_mode, each cs rising edge increments a 2-bit saturating counter; no decode and no writes happen.
  - spi_mode is set on the 3rd cs rise and then stays set until reset.
  - The 4th frame is the first frame decoded.
- FSM states: IDLE, HDR, ADDR, DATA, SKIP.
  - IDLE -> HDR on cs fall while spi_mode=1.
  - HDR: shift 8 bits. If bits[7:1] != CHIP_ADDR -> SKIP; otherwise latch the R/W bit (1 = read) -> ADDR.
  - ADDR: shift 16 bits into the address pointer -> DATA.
  - DATA, write frame: on each 8th bit, if the pointer is in [REG_BASE, REG_BASE+NUM_REGS-1], store the byte and pulse reg_wr_valid for 1 clk with reg_wr_addr/reg_wr_data. Out of range: no store and no pulse. In both cases the pointer then increments by 1, wrapping at 16'hFFFF (burst auto-increment).
  - DATA, read frame: see Optional Feature.
  - SKIP: ignore all bits until cs rise.
- Any state goes to IDLE on cs rise.
  - Partial bytes and a partial address are discarded; no write occurs.
  - A cs rise in the same clk as a completed 8th bit still commits that write (the bit completes first).
- The bit counter resets on every cs fall. A cs fall in IDLE with spi_mode=0 only arms the dummy counter.
- reg_wr_valid never asserts on back-to-back clks: bytes are ≥8 sclk apart.
- core_clk_en updates in the clk after the write to REG_BASE+0 commits.
- reset_n low mid-frame: immediate clear, including spi_mode and the register file. The frame in flight is lost.

Optional Feature:
- Macro ADAU_RESP_READBACK_EN.
- Defined:
  - At entry to each read-frame DATA byte, load the byte at the pointer into a shift register; out-of-range addresses read 0x00.
  - spi_miso presents the MSB from the first sclk fall after ADDR completes and shifts on each subsequent sclk fall.
  - spi_miso_oe=1 from that point until cs rise.
  - The pointer increments after each byte.
- Undefined: spi_miso and spi_miso_oe are tied 0. Read frames are treated as SKIP after HDR and cause no register or output change.

Test Plan:
- Three frames of 0x00000000, then 0x00400001 at 1 MHz sclk / 50 MHz clk -> spi_mode=1 after the 3rd cs rise; one reg_wr_valid with addr 0x4000, data 0x01; core_clk_en=1; no strobe during the dummy frames.
- Fresh reset, then 0x00400001 sent once -> spi_mode=0, no strobe, core_clk_en=0.
- After SPI entry, burst 0x00 0x40F9 0xFF 0x03 in one cs window -> two strobes, (0x40F9,0xFF) then (0x40FA,0x03); register file holds both.
- After writing 0x40 to 0x4016, read frame 0x01 0x4016 + 8 clocks -> MISO returns 0x40 with oe=1 during the data byte (READBACK_EN). Without the macro, MISO/oe stay 0.
- Frame 0x02401C21 (wrong chip address) -> no strobe. A frame aborted by cs rise after 20 bits -> no strobe, and the next valid frame 0x00401E41 writes 0x41 to 0x401E.
- reset_n pulsed low mid-data-byte -> all outputs 0 immediately, register 0x4000 reads 0x00, three dummy frames are needed again.
